onehot_decode_stream: RTL

- Streaming 3-to-8 decoder: the inverse of the team's 8-to-3 priority encoder, where index 0 has the highest priority.
- Accepts 3-bit indices (plus a "no request" flag) over a valid/ready handshake and emits one-hot 8-bit grant vectors through a 2-entry buffer.
- Accumulates every emitted vector into a served-mask with a saturating serve counter.
- Sits downstream of the encoder in the request/grant path, re-expanding encoded winners into per-requester grant lines.

---
 rtl/onehot_decode_stream.sv | 106 ++++++++++
 1 files changed

// File: rtl/onehot_decode_stream.sv
// Decodes 3-bit indices into one-hot grants via a 2-entry FIFO and ORs popped grants into a served mask with a counter.
// Latency: one cycle from push to head when empty; mask/cnt update on the pop edge.
// Backpressure: in_ready comes only from registered occupancy (low when full or in reset); out side is valid/ready.
module onehot_decode_stream #(
    parameter  int IDX_W = 3,
    parameter  int CNT_W = 4,
    localparam int OUT_W = 1 << IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_none,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    input  logic             mask_clr,
    output logic [OUT_W-1:0] mask,
    output logic             mask_full,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       occ;
    logic [OUT_W-1:0] slot0;
    logic [OUT_W-1:0] slot1;
    logic [OUT_W-1:0] in_dat;
    logic             push;
    logic             pop;
    logic             pop_req;
    logic [OUT_W-1:0] mask_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    assign in_ready   = rst_n && (occ != 2'd2);
    assign out_valid  = (occ != 2'd0);
    assign out_onehot = out_valid ? slot0 : '0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    // A none entry decodes to zero, so a non-zero head is exactly a real request.
    assign pop_req    = pop && (|slot0);

    always_comb begin
        in_dat = '0;
        if (!in_none) begin
            in_dat[in_idx] = 1'b1;
        end
    end

    always_comb begin
        mask_nxt = mask;
        cnt_nxt  = cnt;
        if (mask_clr) begin
            mask_nxt = pop ? slot0 : '0;
            cnt_nxt  = pop_req ? CNT_W'(1) : '0;
        end else if (pop) begin
            mask_nxt = mask | slot0;
            if (pop_req && (cnt != CNT_MAX)) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            slot0     <= '0;
            slot1     <= '0;
            mask      <= '0;
            mask_full <= 1'b0;
            cnt       <= '0;
        end else begin
            mask      <= mask_nxt;
            mask_full <= &mask_nxt;
            cnt       <= cnt_nxt;
            case (occ)
                2'd0: begin
                    if (push) begin
                        slot0 <= in_dat;
                        occ   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        slot0 <= in_dat;
                    end else if (push) begin
                        slot1 <= in_dat;
                        occ   <= 2'd2;
                    end else if (pop) begin
                        slot0 <= '0;
                        occ   <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        slot0 <= slot1;
                        slot1 <= '0;
                        occ   <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule
